// File: rtl/hdlc_rx_protocol_checker.sv
// Multi-channel HDLC receive checker: predicts flag/abort strobes from the serial Rx line,
// compares them with the core's strobes at fixed latencies and counts violations per channel.
module hdlc_rx_protocol_checker #(
  parameter int N_CH      = 1,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int CNT_W     = 8,
  parameter int IDLE_ONES = 15,
  localparam int RD_W     = $clog2(N_CH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_CH-1:0]  ChEn,
  input  logic [N_CH-1:0]  Rx,
  input  logic [N_CH-1:0]  Rx_FlagDetect,
  input  logic [N_CH-1:0]  Rx_AbortDetect,
  input  logic [N_CH-1:0]  Rx_ValidFrame,
  input  logic [N_CH-1:0]  Rx_AbortSignal,
  input  logic             ClrCnt,
  input  logic [RD_W-1:0]  RdCh,
  input  logic [1:0]       RdSel,
  output logic [CNT_W-1:0] RdData,
  output logic [1:0]       RdState,
  output logic [N_CH-1:0]  ErrPulse,
  output logic             ErrSticky
);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, ABORTED = 2'd2} state_t;

  logic [CNT_W-1:0] cnt_all [N_CH][4];
  logic [1:0]       st_all  [N_CH];
  logic [N_CH-1:0]  err_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // The 8-bit match window is the 7 stored bits plus the live Rx bit, so a
    // match is flagged in the same cycle the last pattern bit is on the line.
    logic [6:0]           sh;
    logic [3:0]           fill;
    logic [FLAG_LAT-1:0]  fpipe;
    logic [ABORT_LAT-1:0] apipe;
    logic [7:0]           ones;
    logic                 absig_pend;
    logic                 pulse;
    state_t               state;
    logic [CNT_W-1:0]     cnt [4];

    logic [7:0] win;
    logic [3:0] fill_nxt;
    logic [7:0] ones_nxt;
    logic       flag_match;
    logic       abort_match;
    logic [3:0] kind;

    always_comb begin
      win         = {sh, Rx[g]};
      fill_nxt    = (fill == 4'd8) ? fill : fill + 4'd1;
      ones_nxt    = !Rx[g] ? 8'd0 : ((ones == 8'hFF) ? ones : ones + 8'd1);
      flag_match  = ChEn[g] && (fill_nxt == 4'd8) && (win == 8'b0111_1110);
      abort_match = ChEn[g] && (fill_nxt == 4'd8) && (win == 8'b0111_1111);
      kind        = '0;
      if (ChEn[g]) begin
        kind[0] = fpipe[FLAG_LAT-1] && !Rx_FlagDetect[g];
        kind[1] = Rx_FlagDetect[g] && !fpipe[FLAG_LAT-1] && (state != HUNT);
        kind[2] = apipe[ABORT_LAT-1] && !Rx_AbortDetect[g];
        kind[3] = absig_pend && !Rx_AbortSignal[g];
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        sh         <= '0;
        fill       <= '0;
        fpipe      <= '0;
        apipe      <= '0;
        ones       <= '0;
        absig_pend <= 1'b0;
        pulse      <= 1'b0;
        state      <= HUNT;
        for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
        pulse <= |kind;
        // Clear wins over a same-cycle increment; the pulse still reports the event.
        for (int k = 0; k < 4; k++) begin
          if (ClrCnt)
            cnt[k] <= '0;
          else if (kind[k] && (cnt[k] != '1))
            cnt[k] <= cnt[k] + 1'b1;
        end
        if (!ChEn[g]) begin
          sh         <= '0;
          fill       <= '0;
          fpipe      <= '0;
          apipe      <= '0;
          ones       <= '0;
          absig_pend <= 1'b0;
          state      <= HUNT;
        end else begin
          sh         <= win[6:0];
          fill       <= fill_nxt;
          fpipe      <= (fpipe << 1) | FLAG_LAT'(flag_match);
          apipe      <= (apipe << 1) | ABORT_LAT'(abort_match);
          ones       <= ones_nxt;
          absig_pend <= Rx_AbortDetect[g] && Rx_ValidFrame[g];
          case (state)
            HUNT:    if (flag_match) state <= SYNC;
            SYNC:    if (abort_match) state <= ABORTED;
            ABORTED: begin
              if (flag_match)
                state <= SYNC;
              else if (ones_nxt >= 8'(IDLE_ONES))
                state <= HUNT;
            end
            default: state <= HUNT;
          endcase
        end
      end
    end

    assign ErrPulse[g] = pulse;
    assign err_any[g]  = |kind;
    assign st_all[g]   = state;
    assign cnt_all[g]  = cnt;
  end

  always_ff @(posedge Clk) begin
    if (Rst || ClrCnt)
      ErrSticky <= 1'b0;
    else if (|err_any)
      ErrSticky <= 1'b1;
  end

  // Out-of-range channel selects read back as zero.
  always_comb begin
    RdData  = '0;
    RdState = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (RdCh == RD_W'(i)) begin
        RdData  = cnt_all[i][RdSel];
        RdState = st_all[i];
      end
    end
  end

endmodule
